// File: rtl/vram_reader_pkg.sv
// rtl/vram_reader_pkg.sv - shared widths, FSM states and address-step helper for the VRAM stream reader
package vram_reader_pkg;

   localparam int VRAM_ADDR_W = 15;
   localparam int VRAM_DATA_W = 32;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      DRAIN,
      DONE,
      FLUSH
   } state_t;

   // Bits outside the mask stay fixed, so an all-ones mask is a plain +1 with 15-bit wrap.
   function automatic logic [VRAM_ADDR_W-1:0] next_addr(
      input logic [VRAM_ADDR_W-1:0] addr,
      input logic [VRAM_ADDR_W-1:0] mask
   );
      logic [VRAM_ADDR_W-1:0] inc;
      inc = addr + 1'b1;
      return (addr & ~mask) | (inc & mask);
   endfunction

endpackage

// File: rtl/vram_stream_reader_if.sv
// rtl/vram_stream_reader_if.sv - one read-only VRAM arbiter port (strobe/addr/ack/rddata)
interface vram_stream_reader_if;
   import vram_reader_pkg::*;

   logic [VRAM_ADDR_W-1:0] addr;
   logic                   strobe;
   logic                   ack;
   logic [VRAM_DATA_W-1:0] rddata;

   modport master (output addr, output strobe, input ack, input rddata);
   modport slave  (input addr, input strobe, output ack, output rddata);

endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with push/pop/flush and an occupancy count
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   input  logic             flush,
   output logic [WIDTH-1:0] pop_data,
   output logic [AW:0]      count
);

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_pop   = pop && (count != '0);
   assign do_push  = push && ((count != FULL_CNT) || do_pop);
   assign pop_data = (count != '0) ? mem[rd_ptr] : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= push_data;
   end

   assert property (@(posedge clk) disable iff (!rst_n) !(push && !flush && count == FULL_CNT && !pop));

endmodule

// File: rtl/vram_stream_reader.sv
// rtl/vram_stream_reader.sv - streams consecutive VRAM words into a FIFO for a renderer
// Optional tile-map address window: VRAM_READER_WRAP_EN.
module vram_stream_reader
   import vram_reader_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = 9
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [VRAM_ADDR_W-1:0] start_addr,
   input  logic [CNT_W-1:0]       word_count,
`ifdef VRAM_READER_WRAP_EN
   input  logic [VRAM_ADDR_W-1:0] wrap_mask,
`endif
   input  logic                   abort,
   vram_stream_reader_if.master   vram,
   output logic [VRAM_DATA_W-1:0] out_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   busy,
   output logic                   done
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   state_t                 state;
   state_t                 state_nx;
   logic [VRAM_ADDR_W-1:0] req_addr;
   logic [VRAM_ADDR_W-1:0] addr_nx;
   logic [VRAM_ADDR_W-1:0] mask_q;
   logic [CNT_W-1:0]       issue_left;
   logic [CW-1:0]          fifo_count;
   logic                   ack_ok;
   logic                   load;
   logic                   flush;

   // Acks only count while fetching; anything arriving in IDLE/FLUSH is stale.
   assign ack_ok  = vram.ack && (state == FETCH);
   assign addr_nx = next_addr(req_addr, mask_q);
   assign flush   = (state == FLUSH) || (abort && state != IDLE);

   assign vram.addr   = ack_ok ? addr_nx : req_addr;
   assign vram.strobe = (state == FETCH)
                        && (issue_left != CNT_W'(ack_ok))
                        && ((fifo_count + CW'(ack_ok)) < CW'(FIFO_DEPTH));

   assign out_valid = (fifo_count != '0);
   assign busy      = (state != IDLE);
   assign done      = (state == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      load     = 1'b0;
      case (state)
         IDLE: if (start) begin
            load     = 1'b1;
            state_nx = (word_count != '0) ? FETCH : DONE;
         end
         FETCH: if (ack_ok && issue_left == CNT_W'(1)) state_nx = DRAIN;
         DRAIN: if (fifo_count == '0) state_nx = DONE;
         DONE:    state_nx = IDLE;
         FLUSH:   state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
      if (abort && state != IDLE) state_nx = FLUSH;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_addr   <= '0;
         issue_left <= '0;
      end else if (load) begin
         req_addr   <= start_addr;
         issue_left <= word_count;
      end else if (ack_ok) begin
         req_addr   <= addr_nx;
         issue_left <= issue_left - CNT_W'(1);
      end
   end

`ifdef VRAM_READER_WRAP_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    mask_q <= '1;
      else if (load) mask_q <= wrap_mask;
   end
`else
   assign mask_q = '1;
`endif

   sync_fifo #(
      .WIDTH (VRAM_DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (ack_ok && !abort),
      .push_data (vram.rddata),
      .pop       (out_ready),
      .flush     (flush),
      .pop_data  (out_data),
      .count     (fifo_count)
   );

endmodule

// File: tb/tb_vram_stream_reader.sv
// tb/tb_vram_stream_reader.sv - scoreboard bench for vram_stream_reader with a VRAM arbiter model
module tb_vram_stream_reader;
   import vram_reader_pkg::*;

   localparam int CNT_W = 9;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic             abort = 1'b0;
   logic             out_ready = 1'b0;
   logic [14:0]      start_addr = '0;
   logic [CNT_W-1:0] word_count = '0;
`ifdef VRAM_READER_WRAP_EN
   logic [14:0]      wrap_mask = 15'h7FFF;
`endif
   logic [31:0]      out_data;
   logic             out_valid;
   logic             busy;
   logic             done;

   vram_stream_reader_if vram ();

   vram_stream_reader #(
      .FIFO_DEPTH (4),
      .CNT_W      (CNT_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .start_addr (start_addr),
      .word_count (word_count),
`ifdef VRAM_READER_WRAP_EN
      .wrap_mask  (wrap_mask),
`endif
      .abort      (abort),
      .vram       (vram),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   // Arbiter model: withholds the first stall_target requests after each start, then grants.
   int   stall_target = 0;
   int   stall_seen = 0;
   int   grant_cnt = 0;
   logic grant_now;
   assign grant_now = (stall_seen >= stall_target);

   always @(posedge clk) begin
      if (start) begin
         stall_seen <= 0;
         grant_cnt  <= 0;
      end
      if (vram.strobe && grant_now) begin
         vram.ack    <= 1'b1;
         vram.rddata <= 32'hC0DE_0000 | {17'h0, vram.addr};
         grant_cnt   <= grant_cnt + 1;
      end else begin
         vram.ack    <= 1'b0;
         vram.rddata <= 32'hDEAD_BEEF;
         if (vram.strobe && !start) stall_seen <= stall_seen + 1;
      end
   end

   int          n_checks = 0;
   int          n_fail = 0;
   int          done_cnt = 0;
   logic [31:0] exp_q[$];
   logic [14:0] exp_addr_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic expect_run(input logic [14:0] a0, input int n);
      logic [14:0] a;
      a = a0;
      for (int i = 0; i < n; i++) begin
         exp_addr_q.push_back(a);
         exp_q.push_back(32'hC0DE_0000 | {17'h0, a});
         a = a + 15'd1;
      end
   endtask

   task automatic pulse_start(input logic [14:0] a, input logic [CNT_W-1:0] n);
      start_addr = a;
      word_count = n;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int limit, output int strobes, output bit ok);
      strobes = 0;
      ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         if (vram.strobe) strobes++;
         if (done) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   initial begin
      int strobes;
      bit ok;

      fork
         forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
               if (out_valid && out_ready) begin
                  check("word_expected", 32'(exp_q.size() != 0), 32'd1);
                  if (exp_q.size() != 0) check("word_data", out_data, exp_q.pop_front());
               end
               if (vram.strobe && grant_now) begin
                  check("addr_expected", 32'(exp_addr_q.size() != 0), 32'd1);
                  if (exp_addr_q.size() != 0)
                     check("grant_addr", 32'(vram.addr), 32'(exp_addr_q.pop_front()));
               end
               if (done) done_cnt++;
            end
         end
      join_none

      repeat (3) @(negedge clk);
      check("rst_strobe", 32'(vram.strobe), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_addr", 32'(vram.addr), 32'd0);
      check("rst_out_data", out_data, 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Uncontended four-word run
      out_ready = 1'b1;
      done_cnt = 0;
      expect_run(15'h0100, 4);
      check("pre_start_strobe", 32'(vram.strobe), 32'd0);
      pulse_start(15'h0100, 9'd4);
      check("first_strobe", 32'(vram.strobe), 32'd1);
      wait_done(40, strobes, ok);
      check("unc_done_seen", 32'(ok), 32'd1);
      check("unc_strobe_cycles", 32'(strobes), 32'd4);
      check("unc_grants", 32'(grant_cnt), 32'd4);
      @(negedge clk);
      check("unc_busy_after", 32'(busy), 32'd0);
      check("unc_done_once", 32'(done_cnt), 32'd1);
      check("unc_words_left", 32'(exp_q.size()), 32'd0);

      // First request stalled for three cycles
      stall_target = 3;
      expect_run(15'h0100, 4);
      pulse_start(15'h0100, 9'd4);
      for (int i = 0; i < 3; i++) begin
         check("stall_strobe", 32'(vram.strobe), 32'd1);
         check("stall_addr", 32'(vram.addr), 32'h0100);
         @(negedge clk);
      end
      wait_done(40, strobes, ok);
      check("stall_done_seen", 32'(ok), 32'd1);
      check("stall_grants", 32'(grant_cnt), 32'd4);
      stall_target = 0;
      repeat (2) @(negedge clk);

      // Backpressure: FIFO fills at four words, then drains
      out_ready = 1'b0;
      expect_run(15'h0040, 8);
      pulse_start(15'h0040, 9'd8);
      repeat (12) @(negedge clk);
      check("bp_grants_full", 32'(grant_cnt), 32'd4);
      check("bp_strobe_low", 32'(vram.strobe), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_busy", 32'(busy), 32'd1);
      out_ready = 1'b1;
      wait_done(60, strobes, ok);
      check("bp_done_seen", 32'(ok), 32'd1);
      check("bp_grants_all", 32'(grant_cnt), 32'd8);
      repeat (2) @(negedge clk);
      check("bp_words_left", 32'(exp_q.size()), 32'd0);

      // Abort while the first ack is due next cycle
      out_ready = 1'b0;
      done_cnt = 0;
      exp_addr_q.push_back(15'h0200);
      pulse_start(15'h0200, 9'd4);
      check("abort_strobe", 32'(vram.strobe), 32'd1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_ack_arrives", 32'(vram.ack), 32'd1);
      check("abort_valid_1", 32'(out_valid), 32'd0);
      check("abort_strobe_low", 32'(vram.strobe), 32'd0);
      check("abort_busy_1", 32'(busy), 32'd1);
      @(negedge clk);
      check("abort_busy_2", 32'(busy), 32'd0);
      check("abort_valid_2", 32'(out_valid), 32'd0);
      @(negedge clk);
      check("abort_no_done", 32'(done_cnt), 32'd0);
      out_ready = 1'b1;
      expect_run(15'h0300, 2);
      pulse_start(15'h0300, 9'd2);
      wait_done(40, strobes, ok);
      check("restart_done_seen", 32'(ok), 32'd1);
      check("restart_grants", 32'(grant_cnt), 32'd2);
      repeat (2) @(negedge clk);

      // Zero-length run
      pulse_start(15'h0400, 9'd0);
      check("zero_done", 32'(done), 32'd1);
      check("zero_strobe", 32'(vram.strobe), 32'd0);
      @(negedge clk);
      check("zero_done_low", 32'(done), 32'd0);
      check("zero_busy", 32'(busy), 32'd0);
      check("zero_grants", 32'(grant_cnt), 32'd0);

      // Reset in the middle of a run
      out_ready = 1'b0;
      exp_addr_q.push_back(15'h0500);
      exp_addr_q.push_back(15'h0501);
      pulse_start(15'h0500, 9'd8);
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mid_rst_strobe", 32'(vram.strobe), 32'd0);
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_done", 32'(done), 32'd0);
      check("mid_rst_addr", 32'(vram.addr), 32'd0);
      check("mid_rst_data", out_data, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("post_rst_valid", 32'(out_valid), 32'd0);
      check("post_rst_busy", 32'(busy), 32'd0);

`ifdef VRAM_READER_WRAP_EN
      // Wrap inside a 256-word window
      out_ready = 1'b1;
      wrap_mask = 15'h00FF;
      exp_addr_q.push_back(15'h01FE);
      exp_addr_q.push_back(15'h01FF);
      exp_addr_q.push_back(15'h0100);
      exp_addr_q.push_back(15'h0101);
      exp_q.push_back(32'hC0DE_01FE);
      exp_q.push_back(32'hC0DE_01FF);
      exp_q.push_back(32'hC0DE_0100);
      exp_q.push_back(32'hC0DE_0101);
      pulse_start(15'h01FE, 9'd4);
      wait_done(40, strobes, ok);
      check("wrap_done_seen", 32'(ok), 32'd1);
      check("wrap_grants", 32'(grant_cnt), 32'd4);
      wrap_mask = 15'h7FFF;
      repeat (2) @(negedge clk);
`endif

      check("final_words_left", 32'(exp_q.size()), 32'd0);
      check("final_addrs_left", 32'(exp_addr_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
